// File: rtl/x7seg_pkg.sv
// Shared definitions for the 7-segment display path: the segment encoding
// of each hex digit (active-low, bit 6 = a ... bit 0 = g), the decoder
// state encoding and a nibble-mask helper.
package x7seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    typedef enum logic [1:0] {
        WAIT_STABLE = 2'd0,
        SAMPLE      = 2'd1,
        HOLD        = 2'd2
    } state_t;

    // Expand a per-digit mask into a per-bit mask over the packed nibbles.
    function automatic logic [4*NUM_DIGITS-1:0] nibble_mask(input logic [NUM_DIGITS-1:0] mask);
        logic [4*NUM_DIGITS-1:0] m;
        m = {(4*NUM_DIGITS){1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            m[4*i +: 4] = {4{mask[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Reverse lookup of an active-low segment pattern to its hex nibble.
// Patterns outside the shared table give nibble 0 with ok low.
module seg_to_hex
    import x7seg_pkg::*;
(
    input  logic [6:0] a_to_g,
    output logic [3:0] nibble,
    output logic       ok
);

    // Table lookup; unknown patterns fall through to the default.
    always_comb begin
        nibble = 4'h0;
        ok     = 1'b1;
        case (a_to_g)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                ok     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/x7seg_decode.sv
// Recovers the value shown on a multiplexed 7-segment display by watching
// its anode and segment lines. Each digit dwell is sampled once after the
// lines have been stable for STABLE_CYC cycles; once every digit in
// DIGIT_MASK has been seen the assembled value is published on x.
module x7seg_decode
    import x7seg_pkg::*;
#(
    parameter int unsigned              STABLE_CYC = 4,
    parameter int unsigned              TIMEOUT    = 65535,
    parameter logic [NUM_DIGITS-1:0]    DIGIT_MASK = 4'b0011
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [6:0]                  a_to_g,
    input  logic [NUM_DIGITS-1:0]       an,
    output logic [4*NUM_DIGITS-1:0]     x,
    output logic                        valid,
    output logic                        err,
    output logic                        stale
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYC + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
    localparam logic [4*NUM_DIGITS-1:0] X_MASK = nibble_mask(DIGIT_MASK);

    logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2, r_an_prev;
    logic [6:0]              r_seg_s1, r_seg_s2, r_seg_prev;
    logic [STAB_W-1:0]       r_stab_cnt;
    logic [TO_W-1:0]         r_to_cnt;
    state_t                  r_state;
    logic [1:0]              r_smp_dig;
    logic [6:0]              r_smp_seg;
    logic [4*NUM_DIGITS-1:0] r_slots;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_ferr;
    logic [4*NUM_DIGITS-1:0] r_x;
    logic                    r_valid;
    logic                    r_err;
    logic                    r_stale;

    logic                    w_an_chg;
    logic                    w_chg;
    logic [STAB_W-1:0]       w_stab_next;
    logic [1:0]              w_digit;
    logic                    w_onehot;
    logic                    w_go;
    logic                    w_sample;
    logic                    w_complete;
    logic                    w_to_fire;
    logic [3:0]              w_nib;
    logic                    w_ok;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    logic                    w_ferr_next;

    seg_to_hex u_seg_to_hex (
        .a_to_g (r_smp_seg),
        .nibble (w_nib),
        .ok     (w_ok)
    );

    // Two-flop synchronizers plus a third copy used only for change detection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_an_s1    <= {NUM_DIGITS{1'b1}};
            r_an_s2    <= {NUM_DIGITS{1'b1}};
            r_an_prev  <= {NUM_DIGITS{1'b1}};
            r_seg_s1   <= 7'b1111111;
            r_seg_s2   <= 7'b1111111;
            r_seg_prev <= 7'b1111111;
        end else begin
            r_an_s1    <= an;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
            r_seg_s1   <= a_to_g;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
        end
    end

    // Change detection and next stability count (restarts at 0, saturates).
    always_comb begin
        w_an_chg = (r_an_s2 != r_an_prev);
        w_chg    = w_an_chg || (r_seg_s2 != r_seg_prev);
        if (w_chg) begin
            w_stab_next = {STAB_W{1'b0}};
        end else if (r_stab_cnt == STAB_MAX) begin
            w_stab_next = STAB_MAX;
        end else begin
            w_stab_next = r_stab_cnt + STAB_ONE;
        end
    end

    // Stability counter register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_stab_cnt <= {STAB_W{1'b0}};
        end else begin
            r_stab_cnt <= w_stab_next;
        end
    end

    // Which single digit is selected; blanking and multi-select are rejected.
    always_comb begin
        w_digit  = 2'd0;
        w_onehot = 1'b1;
        case (r_an_s2)
            4'b1110: w_digit = 2'd0;
            4'b1101: w_digit = 2'd1;
            4'b1011: w_digit = 2'd2;
            4'b0111: w_digit = 2'd3;
            default: begin
                w_digit  = 2'd0;
                w_onehot = 1'b0;
            end
        endcase
    end

    // The FSM leaves WAIT_STABLE on the same edge the counter reaches its limit.
    assign w_go       = (r_state == WAIT_STABLE) && (w_stab_next == STAB_MAX)
                        && w_onehot && DIGIT_MASK[w_digit];
    assign w_sample   = (r_state == SAMPLE);
    assign w_complete = ((r_seen & DIGIT_MASK) == DIGIT_MASK);
    assign w_to_fire  = !w_sample && (r_to_cnt == TO_LAST);

    // Dwell FSM: latch the stable digit, sample it once, hold until an moves.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= WAIT_STABLE;
            r_smp_dig <= 2'd0;
            r_smp_seg <= 7'b1111111;
        end else begin
            case (r_state)
                WAIT_STABLE: begin
                    if (w_go) begin
                        r_state   <= SAMPLE;
                        r_smp_dig <= w_digit;
                        r_smp_seg <= r_seg_s2;
                    end else begin
                        r_state   <= WAIT_STABLE;
                    end
                end
                SAMPLE:  r_state <= w_an_chg ? WAIT_STABLE : HOLD;
                HOLD:    r_state <= w_an_chg ? WAIT_STABLE : HOLD;
                default: r_state <= WAIT_STABLE;
            endcase
        end
    end

    // Frame bookkeeping: completion or timeout clears, a sample then adds its digit.
    always_comb begin
        w_seen_next = r_seen;
        w_ferr_next = r_ferr;
        if (w_complete || w_to_fire) begin
            w_seen_next = {NUM_DIGITS{1'b0}};
            w_ferr_next = 1'b0;
        end else begin
            w_seen_next = r_seen;
            w_ferr_next = r_ferr;
        end
        if (w_sample) begin
            w_seen_next[r_smp_dig] = 1'b1;
            w_ferr_next            = w_ferr_next | ~w_ok;
        end else begin
            w_seen_next = w_seen_next;
        end
    end

    // Digit slots, seen set and frame-error flag.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_slots <= {(4*NUM_DIGITS){1'b0}};
            r_seen  <= {NUM_DIGITS{1'b0}};
            r_ferr  <= 1'b0;
        end else begin
            if (w_sample) begin
                r_slots[{r_smp_dig, 2'b00} +: 4] <= w_nib;
            end else begin
                r_slots <= r_slots;
            end
            r_seen <= w_seen_next;
            r_ferr <= w_ferr_next;
        end
    end

    // Cycles since the last accepted digit, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if (w_sample) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TO_ONE;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    // Published outputs; a completing frame takes priority over a timeout.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_x     <= {(4*NUM_DIGITS){1'b0}};
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_stale <= 1'b0;
        end else if (w_complete) begin
            r_x     <= r_slots & X_MASK;
            r_valid <= 1'b1;
            r_err   <= r_ferr;
            r_stale <= 1'b0;
        end else if (w_to_fire) begin
            r_valid <= 1'b0;
            r_stale <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign x     = r_x;
    assign valid = r_valid;
    assign err   = r_err;
    assign stale = r_stale;

endmodule

// File: tb/tb_x7seg_decode.sv
// Directed bench for x7seg_decode: drives scanned digit dwells and checks
// the published value, flags, pulse counts and sampling latency.
module tb_x7seg_decode;

    localparam int S  = 4;
    localparam int TO = 300;

    localparam logic [6:0] P_0 = 7'b0000001;
    localparam logic [6:0] P_1 = 7'b1001111;
    localparam logic [6:0] P_2 = 7'b0010010;
    localparam logic [6:0] P_3 = 7'b0000110;
    localparam logic [6:0] P_4 = 7'b1001100;
    localparam logic [6:0] P_5 = 7'b0100100;
    localparam logic [6:0] P_6 = 7'b0100000;
    localparam logic [6:0] P_7 = 7'b0001111;
    localparam logic [6:0] P_8 = 7'b0000000;
    localparam logic [6:0] P_9 = 7'b0000100;
    localparam logic [6:0] P_A = 7'b0001000;
    localparam logic [6:0] P_B = 7'b1100000;
    localparam logic [6:0] P_C = 7'b0110001;
    localparam logic [6:0] P_E = 7'b0110000;
    localparam logic [6:0] P_F = 7'b0111000;
    localparam logic [6:0] P_BAD = 7'b1111110;

    logic        clk = 1'b0;
    logic        clr;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic [15:0] x;
    logic        valid;
    logic        err;
    logic        stale;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int base    = 0;
    int lat     = 0;

    always #5 clk = ~clk;

    x7seg_decode #(
        .STABLE_CYC (S),
        .TIMEOUT    (TO),
        .DIGIT_MASK (4'b0011)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .a_to_g (a_to_g),
        .an     (an),
        .x      (x),
        .valid  (valid),
        .err    (err),
        .stale  (stale)
    );

    // Count valid pulses, sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid) n_valid <= n_valid + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold one anode/segment combination for n cycles, ending just after a falling edge.
    task automatic dwell(input logic [3:0] an_v, input logic [6:0] seg_v, input int n);
        an     = an_v;
        a_to_g = seg_v;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        clr    = 1'b0;
        an     = 4'b1111;
        a_to_g = 7'b1111111;
        #12;
        check_eq("rst_x", 32'(x), 32'h0000);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_stale", 32'(stale), 32'h0);
        @(negedge clk);
        clr = 1'b1;
        dwell(4'b1111, 7'b1111111, 8);

        // digit 1 = b, then digit 0 = 5; measure latency of the last digit
        base = n_valid;
        dwell(4'b1101, P_B, 20);
        an     = 4'b1110;
        a_to_g = P_5;
        lat    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (valid && lat == 0) lat = k;
        end
        dwell(4'b1110, P_5, 10);
        // edge 1 first samples the settled inputs; valid follows 2+S+2 edges later
        check_eq("latency", 32'(lat), 32'(1 + 2 + S + 2));
        check_eq("b5_x", 32'(x), 32'h00B5);
        check_eq("b5_err", 32'(err), 32'h0);
        check_eq("b5_stale", 32'(stale), 32'h0);
        check_eq("b5_pulses", 32'(n_valid - base), 32'd1);

        // x = 7F, digit 0 first
        dwell(4'b1111, 7'b1111111, 8);
        base = n_valid;
        dwell(4'b1110, P_F, 20);
        dwell(4'b1101, P_7, 20);
        dwell(4'b1111, 7'b1111111, 4);
        check_eq("7f_x", 32'(x), 32'h007F);
        check_eq("7f_err", 32'(err), 32'h0);
        check_eq("7f_pulses", 32'(n_valid - base), 32'd1);

        // undecodable digit 1, then a clean frame
        dwell(4'b1101, P_BAD, 20);
        dwell(4'b1110, P_3, 20);
        dwell(4'b1111, 7'b1111111, 4);
        check_eq("bad_x", 32'(x), 32'h0003);
        check_eq("bad_err", 32'(err), 32'h1);
        dwell(4'b1110, P_0, 20);
        dwell(4'b1101, P_1, 20);
        dwell(4'b1111, 7'b1111111, 4);
        check_eq("clean_x", 32'(x), 32'h0010);
        check_eq("clean_err", 32'(err), 32'h0);

        // blanking and two-anode phases sample nothing
        base = n_valid;
        dwell(4'b1111, P_8, 20);
        dwell(4'b1100, P_8, 20);
        check_eq("blank_pulses", 32'(n_valid - base), 32'd0);
        check_eq("blank_x", 32'(x), 32'h0010);

        // short glitch before digit 0 settles, plus a masked digit 2 dwell
        dwell(4'b1110, P_E, 2);
        dwell(4'b1110, P_A, 20);
        dwell(4'b1011, P_9, 20);
        check_eq("glitch_partial", 32'(n_valid - base), 32'd0);
        dwell(4'b1101, P_C, 20);
        dwell(4'b1111, 7'b1111111, 4);
        check_eq("glitch_x", 32'(x), 32'h00CA);
        check_eq("glitch_pulses", 32'(n_valid - base), 32'd1);

        // scan stops after digit 0
        base = n_valid;
        dwell(4'b1110, P_1, 20);
        dwell(4'b1111, P_8, 100);
        check_eq("to_early_stale", 32'(stale), 32'h0);
        dwell(4'b1111, P_8, 250);
        check_eq("to_stale", 32'(stale), 32'h1);
        check_eq("to_x_held", 32'(x), 32'h00CA);
        dwell(4'b1101, P_2, 20);
        check_eq("to_partial_pulses", 32'(n_valid - base), 32'd0);
        check_eq("to_partial_stale", 32'(stale), 32'h1);
        dwell(4'b1110, P_4, 20);
        dwell(4'b1111, 7'b1111111, 4);
        check_eq("resume_x", 32'(x), 32'h0024);
        check_eq("resume_stale", 32'(stale), 32'h0);
        check_eq("resume_pulses", 32'(n_valid - base), 32'd1);

        // reset after digit 0 is sampled
        base = n_valid;
        dwell(4'b1110, P_6, 20);
        #2;
        clr = 1'b0;
        #1;
        check_eq("mid_rst_x", 32'(x), 32'h0000);
        check_eq("mid_rst_valid", 32'(valid), 32'h0);
        check_eq("mid_rst_err", 32'(err), 32'h0);
        check_eq("mid_rst_stale", 32'(stale), 32'h0);
        repeat (3) @(negedge clk);
        #1;
        clr = 1'b1;
        dwell(4'b1101, P_7, 30);
        check_eq("post_rst_pulses", 32'(n_valid - base), 32'd0);
        check_eq("post_rst_x", 32'(x), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
